// File: rtl/sd_card_cmd.sv
// SPI-mode SD command engine: serialises a 48-bit command frame, polls for R1,
// optionally reads the OCR (CMD58) and reports a decoded status with two confirm pulses.
module sd_card_cmd #(
  parameter int SLOW_HALF_PERIOD = 125,
  parameter int FAST_HALF_PERIOD = 1,
  parameter int NCR_MAX          = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clk_fast,
  input  logic        i_send_cmd,
  input  logic [2:0]  i_cmd_select,
  input  logic [31:0] i_cmd_arg,
  output logic        o_confirm_pin,
  output logic [7:0]  o_response_status,
  output logic [31:0] o_ocr,
  output logic        o_busy,
  output logic        o_sd_sclk,
  output logic        o_sd_mosi,
  input  logic        i_sd_miso
);

  localparam int HP_MAX = (SLOW_HALF_PERIOD > FAST_HALF_PERIOD) ? SLOW_HALF_PERIOD : FAST_HALF_PERIOD;
  localparam int HW     = $clog2(HP_MAX + 1);
  localparam int BCW    = $clog2(NCR_MAX + 1);

  localparam logic [2:0] SEL_CMD0  = 3'd1;
  localparam logic [2:0] SEL_CMD55 = 3'd5;
  localparam logic [2:0] SEL_CMD58 = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SEND,
    S_WAIT_R1,
    S_READ_OCR,
    S_POST,
    S_DONE
  } state_t;

  state_t          state_reg, state_next;
  logic [2:0]      cmd_reg;
  logic [HW-1:0]   half_reg;
  logic [HW-1:0]   div_reg;
  logic            sclk_reg;
  logic [55:0]     tx_reg;
  logic [31:0]     rx_reg;
  logic [5:0]      bit_cnt_reg;
  logic [BCW-1:0]  byte_cnt_reg;
  logic            pulse1_reg;
  logic [7:0]      status_reg;
  logic [7:0]      r1_reg;
  logic            timeout_reg;
  logic [31:0]     ocr_reg;

  logic accept;
  logic shifting;
  logic tick;
  logic rise;
  logic bit_end;
  logic poll_byte_done;
  logic state_change;

  function automatic logic [5:0] cmd_index(input logic [2:0] sel);
    case (sel)
      3'd1:    cmd_index = 6'd0;
      3'd2:    cmd_index = 6'd16;
      3'd3:    cmd_index = 6'd17;
      3'd4:    cmd_index = 6'd24;
      3'd5:    cmd_index = 6'd55;
      3'd6:    cmd_index = 6'd58;
      3'd7:    cmd_index = 6'd41;
      default: cmd_index = 6'd0;
    endcase
  endfunction

  // R1 decode, highest-priority error bit first; ACMD41 busy (0x01) falls through to idle.
  function automatic logic [7:0] decode_r1(input logic [2:0] sel, input logic [7:0] r1);
    if (r1 == 8'h00)                                          decode_r1 = 8'd1;
    else if (r1 == 8'h01 && (sel == SEL_CMD0 || sel == SEL_CMD55)) decode_r1 = 8'd1;
    else if (r1[6])                                           decode_r1 = 8'd3;
    else if (r1[5])                                           decode_r1 = 8'd4;
    else if (r1[4])                                           decode_r1 = 8'd5;
    else if (r1[3])                                           decode_r1 = 8'd6;
    else if (r1[2])                                           decode_r1 = 8'd7;
    else if (r1[1])                                           decode_r1 = 8'd8;
    else                                                      decode_r1 = 8'd2;
  endfunction

  assign accept         = (state_reg == S_IDLE) && i_send_cmd && (i_cmd_select != 3'd0);
  assign shifting       = (state_reg != S_IDLE) && (state_reg != S_DONE);
  assign tick           = shifting && (div_reg == half_reg - HW'(1));
  assign rise           = tick && !sclk_reg;
  assign bit_end        = tick && sclk_reg;
  assign poll_byte_done = (state_reg == S_WAIT_R1) && bit_end && (bit_cnt_reg == 6'd7);
  assign state_change   = (state_next != state_reg);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:     if (accept) state_next = S_PRE;
      S_PRE:      if (bit_end && bit_cnt_reg == 6'd7) state_next = S_SEND;
      S_SEND:     if (bit_end && bit_cnt_reg == 6'd47) state_next = S_WAIT_R1;
      S_WAIT_R1: begin
        if (poll_byte_done) begin
          if (!rx_reg[7])
            state_next = (cmd_reg == SEL_CMD58) ? S_READ_OCR : S_POST;
          else if (byte_cnt_reg == BCW'(NCR_MAX - 1))
            state_next = S_POST;
        end
      end
      S_READ_OCR: if (bit_end && bit_cnt_reg == 6'd31) state_next = S_POST;
      S_POST:     if (bit_end && bit_cnt_reg == 6'd7) state_next = S_DONE;
      S_DONE:     state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy        = (state_reg != S_IDLE);
    o_confirm_pin = pulse1_reg || (state_reg == S_DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cmd_reg      <= 3'd0;
      half_reg     <= '0;
      div_reg      <= '0;
      sclk_reg     <= 1'b0;
      tx_reg       <= '1;
      rx_reg       <= '0;
      bit_cnt_reg  <= '0;
      byte_cnt_reg <= '0;
      pulse1_reg   <= 1'b0;
      status_reg   <= 8'd0;
      r1_reg       <= 8'hFF;
      timeout_reg  <= 1'b0;
      ocr_reg      <= 32'd0;
    end else begin
      pulse1_reg <= (state_reg == S_SEND) && (state_next == S_WAIT_R1);

      if (accept) begin
        cmd_reg      <= i_cmd_select;
        half_reg     <= i_clk_fast ? HW'(FAST_HALF_PERIOD) : HW'(SLOW_HALF_PERIOD);
        status_reg   <= 8'd0;
        timeout_reg  <= 1'b1;
        byte_cnt_reg <= '0;
        tx_reg       <= {8'hFF, 2'b01, cmd_index(i_cmd_select), i_cmd_arg,
                         (i_cmd_select == SEL_CMD0) ? 8'h95 : 8'h01};
      end else if (bit_end) begin
        tx_reg <= {tx_reg[54:0], 1'b1};
      end

      div_reg <= (!shifting || tick) ? '0 : div_reg + HW'(1);

      if (!shifting)  sclk_reg <= 1'b0;
      else if (tick)  sclk_reg <= ~sclk_reg;

      if (rise) rx_reg <= {rx_reg[30:0], i_sd_miso};

      if (state_change || poll_byte_done) bit_cnt_reg <= '0;
      else if (bit_end)                   bit_cnt_reg <= bit_cnt_reg + 6'd1;

      // A poll byte with bit7 clear is R1; otherwise keep polling until NCR_MAX bytes.
      if (poll_byte_done) begin
        byte_cnt_reg <= byte_cnt_reg + BCW'(1);
        if (!rx_reg[7]) begin
          r1_reg      <= rx_reg[7:0];
          timeout_reg <= 1'b0;
        end
      end

      if (state_reg == S_READ_OCR && bit_end && bit_cnt_reg == 6'd31)
        ocr_reg <= rx_reg;

      if (state_reg == S_POST && state_next == S_DONE)
        status_reg <= timeout_reg ? 8'd0 : decode_r1(cmd_reg, r1_reg);
    end
  end

  assign o_sd_sclk         = sclk_reg;
  assign o_sd_mosi         = tx_reg[55];
  assign o_response_status = status_reg;
  assign o_ocr             = ocr_reg;

endmodule
